// File: rtl/dmem_access_ctrl.sv
// Data-memory bus initiator: takes one load/store at a time from the pipeline,
// sequences the memory strobes and returns a single-cycle response that also
// tells the pipeline whether the access hit the memory-mapped switch/LED word.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | bus quiet, ready for a request
// WRITE | memWr strobe cycle (exactly one cycle)
// READ  | memRd held for RD_LATENCY cycles, datard captured at end
// RESP  | rsp_valid pulse, then back to IDLE
module dmem_access_ctrl #(
    parameter int                 ADDR_W     = 13,
    parameter int                 DATA_W     = 64,
    parameter int                 RD_LATENCY = 1,   // 1..15
    parameter logic [ADDR_W-1:0]  IO_ADDR    = 13'h100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_io,
    output logic [ADDR_W-1:0] Addres,
    output logic              memWr,
    output logic              memRd,
    output logic [DATA_W-1:0] datawr,
    input  logic [DATA_W-1:0] datard
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Index of the final READ cycle; the counter runs 0..LAST_RD.
    localparam logic [3:0] LAST_RD = 4'(RD_LATENCY - 1);

    logic [1:0] state;
    logic [3:0] lat_cnt;
    logic       io_q;

    // Acceptance only in IDLE and never while reset is held.
    assign req_ready = (state == IDLE) & ~rst;

    // Sequencer: all bus and response outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= 4'd0;
            io_q      <= 1'b0;
            Addres    <= '0;
            memWr     <= 1'b0;
            memRd     <= 1'b0;
            datawr    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_io    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    memWr     <= 1'b0;
                    memRd     <= 1'b0;
                    Addres    <= '0;
                    datawr    <= '0;
                    rsp_valid <= 1'b0;
                    rsp_io    <= 1'b0;
                    if (req_valid) begin
                        // Address and data go straight into the bus registers,
                        // so later req_* changes cannot disturb the access.
                        io_q   <= (req_addr == IO_ADDR);
                        Addres <= req_addr;
                        if (req_wr) begin
                            datawr <= req_wdata;
                            memWr  <= 1'b1;
                            state  <= WRITE;
                        end else begin
                            memRd   <= 1'b1;
                            lat_cnt <= 4'd0;
                            state   <= READ;
                        end
                    end
                end
                WRITE: begin
                    memWr     <= 1'b0;
                    Addres    <= '0;
                    datawr    <= '0;
                    rsp_valid <= 1'b1;
                    rsp_io    <= io_q;
                    state     <= RESP;
                end
                READ: begin
                    if (lat_cnt == LAST_RD) begin
                        memRd     <= 1'b0;
                        Addres    <= '0;
                        rsp_rdata <= datard;
                        rsp_valid <= 1'b1;
                        rsp_io    <= io_q;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_io    <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized scoreboard bench for dmem_access_ctrl with a bus-side memory
// model (RAM + switch/LED word) and a transaction-level reference model.
module tb_dmem_access_ctrl;

    localparam int          AW  = 13;
    localparam int          DW  = 64;
    localparam int          LAT = 3;
    localparam logic [12:0] IO  = 13'h100;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_io;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] Addres;
    logic          memWr, memRd;
    logic [DW-1:0] datawr, datard;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .IO_ADDR(IO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_io(rsp_io),
        .Addres(Addres), .memWr(memWr), .memRd(memRd),
        .datawr(datawr), .datard(datard)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus-side memory model ----------------
    logic [63:0] phys [int];
    logic [7:0]  leds   = 8'h00;
    logic [63:0] sw     = 64'd0;
    int          rd_cyc = 0;

    initial forever begin
        @(posedge clk);
        if (memWr) begin
            if (Addres == IO) leds <= datawr[7:0];
            else phys[int'(Addres)] = datawr;
        end
        rd_cyc <= memRd ? rd_cyc + 1 : 0;
    end

    // Valid data only appears on the last memRd cycle; garbage otherwise.
    always @* begin
        if (memRd && rd_cyc == LAT - 1) begin
            if (Addres == IO) datard = sw;
            else if (phys.exists(int'(Addres))) datard = phys[int'(Addres)];
            else datard = 64'd0;
        end else begin
            datard = 64'hBADC_0DE0_BADC_0DE0 ^ 64'(cyc);
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [63:0] wdata;
        logic        io;
        logic [63:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sbq [$];
    logic [63:0] ref_mem [int];
    logic [63:0] last_load = 64'd0;
    logic [7:0]  ref_leds  = 8'h00;
    int          accepted  = 0;
    int          responded = 0;
    int          dropped   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_read(input logic [12:0] a);
        if (a == IO) return sw;
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 64'd0;
    endfunction

    // Called at a negedge; leaves req_valid high so back-to-back calls keep
    // the request line asserted while the controller is busy.
    task automatic issue(input logic wr, input logic [12:0] a, input logic [63:0] d);
        int   budget;
        exp_t e;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        budget = 0;
        while (!req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        e.wr = wr; e.addr = a; e.wdata = d; e.io = (a == IO); e.acc = cyc;
        if (wr) begin
            e.lat = 2;
            if (a == IO) ref_leds = d[7:0];
            else ref_mem[int'(a)] = d;
        end else begin
            e.lat = LAT + 1;
            last_load = ref_read(a);
        end
        e.rdata = last_load;
        sbq.push_back(e);
        accepted++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) check("drain_timeout", 64'(sbq.size()), 64'd0);
        @(negedge clk);
    endtask

    function automatic logic [12:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return IO;
            3:       return 13'($urandom);
            default: return 13'($urandom_range(0, 15));
        endcase
    endfunction

    // ---------------- monitor ----------------
    int          wr_run = 0, rd_run = 0;
    logic [12:0] win_addr;
    logic [63:0] win_data;
    exp_t        m;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            wr_run = 0;
            rd_run = 0;
        end else begin
            if (memWr && memRd) check("strobe_overlap", 64'd1, 64'd0);
            if (!rsp_valid && rsp_io) check("rsp_io_idle", 64'd1, 64'd0);

            if (memWr) begin
                if (wr_run == 0) begin
                    win_addr = Addres; win_data = datawr;
                    if (sbq.size() == 0) check("memwr_no_req", 64'd1, 64'd0);
                    else begin
                        check("memwr_is_store", 64'(sbq[0].wr), 64'd1);
                        check("memwr_addr", 64'(Addres), 64'(sbq[0].addr));
                        check("memwr_data", datawr, sbq[0].wdata);
                    end
                end else begin
                    check("memwr_addr_stable", 64'(Addres), 64'(win_addr));
                    check("memwr_data_stable", datawr, win_data);
                end
                wr_run++;
            end else if (wr_run != 0) begin
                check("memwr_len", 64'(wr_run), 64'd1);
                wr_run = 0;
            end

            if (memRd) begin
                if (rd_run == 0) begin
                    win_addr = Addres;
                    if (sbq.size() == 0) check("memrd_no_req", 64'd1, 64'd0);
                    else begin
                        check("memrd_is_load", 64'(sbq[0].wr), 64'd0);
                        check("memrd_addr", 64'(Addres), 64'(sbq[0].addr));
                    end
                end else begin
                    check("memrd_addr_stable", 64'(Addres), 64'(win_addr));
                end
                rd_run++;
            end else if (rd_run != 0) begin
                check("memrd_len", 64'(rd_run), 64'(LAT));
                rd_run = 0;
            end

            if (rsp_valid) begin
                responded++;
                if (sbq.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
                else begin
                    m = sbq.pop_front();
                    check("rsp_io", 64'(rsp_io), 64'(m.io));
                    check("rsp_rdata", rsp_rdata, m.rdata);
                    check("rsp_latency", 64'(cyc - m.acc), 64'(m.lat));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_strobes", 64'({memWr, memRd}), 64'd0);
        check("rst_addres", 64'(Addres), 64'd0);
        check("rst_datawr", datawr, 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        rst = 1'b0;
        #1 check("ready_after_rst", 64'(req_ready), 64'd1);
        @(negedge clk);

        // Store to the LED word.
        issue(1'b1, IO, 64'd7);
        req_valid = 1'b0;
        drain();
        check("led_model", 64'(leds), 64'h07);

        // Store then load the same RAM word, request line held high.
        issue(1'b1, 13'h000, 64'd8);
        issue(1'b0, 13'h000, 64'd0);
        req_valid = 1'b0;
        drain();

        // Load the switch word.
        sw = 64'd9;
        issue(1'b0, IO, 64'd0);
        req_valid = 1'b0;
        drain();

        // Load whose data only appears on the last memRd cycle.
        issue(1'b1, 13'h005, 64'hDEAD_BEEF_0000_0001);
        issue(1'b0, 13'h005, 64'd0);
        req_valid = 1'b0;
        drain();

        // Reset during the second READ cycle.
        issue(1'b0, 13'h005, 64'd0);
        req_valid = 1'b0;          // now in first READ cycle
        @(negedge clk);            // second READ cycle
        rst = 1'b1;
        @(negedge clk);
        check("midrst_memrd", 64'(memRd), 64'd0);
        check("midrst_addres", 64'(Addres), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_rsp_rdata", rsp_rdata, 64'd0);
        check("midrst_ready_low", 64'(req_ready), 64'd0);
        dropped += sbq.size();
        sbq.delete();
        last_load = 64'd0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_ready_after", 64'(req_ready), 64'd1);
        @(negedge clk);
        check("midrst_no_rsp", 64'(rsp_valid), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                req_wr    = 1'($urandom);
                req_addr  = rand_addr();
                req_wdata = {$urandom, $urandom};
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            if ($urandom_range(0, 15) == 0) begin
                req_valid = 1'b0;
                drain();
                sw = {$urandom, $urandom};
            end
        end
        req_valid = 1'b0;
        drain();

        check("rsp_count", 64'(responded), 64'(accepted - dropped));
        check("led_final", 64'(leds), 64'(ref_leds));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator-side controller for the processor data-memory bus. Drives the 13-bit address, read strobe, write strobe and 64-bit write data, and captures the 64-bit read data.
- Accepts one load/store request at a time from the pipeline over a valid/ready handshake, then returns a one-cycle response.
- Flags accesses to the memory-mapped IO word (switches on read, LEDs on write) so the pipeline can tell IO traffic from RAM traffic.

Parameters:
- ADDR_W, 13, memory bus address width.
- DATA_W, 64, memory bus data width.
- RD_LATENCY, 1, cycles memRd is held before datard is sampled; legal range 1..15, 0 is illegal.
- IO_ADDR, 13'h100, address of the memory-mapped switch/LED word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  controller can accept a request.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle completion pulse, for both loads and stores.
- rsp_rdata  out  DATA_W  load result.
- rsp_io  out  1  completed access targeted IO_ADDR.
- Addres  out  ADDR_W  memory address.
- memWr  out  1  memory write strobe.
- memRd  out  1  memory read strobe.
- datawr  out  DATA_W  memory write data.
- datard  in  DATA_W  memory read data.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, latency counter=0.
- Reset values: Addres=0, memWr=0, memRd=0, datawr=0, rsp_valid=0, rsp_rdata=0, rsp_io=0.
- req_ready = (state==IDLE) & ~rst, combinational.
- All other outputs are registered.
- States are IDLE, WRITE, READ, RESP.
- IDLE:
  - memWr=memRd=0, Addres=0, datawr=0.
  - On req_valid&req_ready, latch addr, wdata, wr and io=(req_addr==IO_ADDR).
  - Go to WRITE if wr=1, else to READ.
- WRITE (exactly 1 cycle):
  - memWr=1, Addres=latched addr, datawr=latched wdata.
  - Next state RESP.
- READ (exactly RD_LATENCY cycles):
  - memRd=1, Addres=latched addr, both held stable.
  - Counter counts 0..RD_LATENCY-1.
  - On the edge ending the last READ cycle, datard is captured into rsp_rdata.
  - Next state RESP.
- RESP (1 cycle):
  - rsp_valid=1, rsp_io=latched io, memRd=memWr=0.
  - Next state IDLE.
- Timing, with acceptance on the edge ending cycle N:
  - Store: memWr high in N+1, rsp_valid in N+2, req_ready high again in N+3.
  - Load: memRd high in N+1..N+RD_LATENCY, rsp_valid in N+RD_LATENCY+1.
  - Maximum throughput is one store per 3 cycles and one load per RD_LATENCY+2 cycles.
- rsp_rdata holds the last load value until the next load capture; stores do not modify it.
- rsp_io is valid only while rsp_valid=1; it is 0 otherwise.
- req_valid while req_ready=0 is ignored; the request is not queued, and the requester must hold it.
- Changes on req_* after acceptance have no effect on the in-flight access.
- memWr and memRd are never high in the same cycle.
- Addres and datawr are stable for the whole strobe window.
- Reset mid-operation (any state): on the reset edge all outputs return to their reset values and the in-flight access is dropped with no rsp_valid. A store already strobed stays in memory.
- IO detection is a full-width compare only; there is no partial decode.

Test Plan:
- Store 7 to 13'h100 -> memWr=1 for exactly one cycle with Addres=13'h100, datawr=7; LED model shows 8'h07; next cycle rsp_valid=1, rsp_io=1.
- Store 8 to 13'h000, then load 13'h000 (RD_LATENCY=1) -> memRd high for 1 cycle; rsp_valid on cycle N+2 with rsp_rdata=64'd8, rsp_io=0.
- Switch model sw=9, load 13'h100 -> rsp_rdata=64'd9, rsp_io=1; memWr stays 0 throughout.
- RD_LATENCY=3, memory model returning 64'hDEADBEEF_00000001 only on the 3rd memRd cycle -> memRd high for exactly 3 cycles; rsp_rdata=64'hDEADBEEF_00000001 at rsp_valid.
- req_valid held high continuously with alternating store/load -> req_ready low while busy; no request lost or duplicated; memWr and memRd never both high; one rsp_valid pulse per accepted request.
- rst asserted during the 2nd READ cycle (RD_LATENCY=3) -> next cycle memRd=0, Addres=0, no rsp_valid; req_ready=1 in the first cycle after rst deasserts.
